cpu6_trap_ctrl: RTL and testbench
=================================

// Module: cpu6_trap_ctrl
// PURPOSE
//  Trap sequencer for cpu6: picks the winning trap source, drains the pipeline, stacks mstatus and writes mepc/mcause.
//  Then redirects fetch to the handler; also sequences mret.
//  Sits between the commit stage, the CSR file and the fetch-redirect mux.
//  Replaces the combinational flush path so that trap entry/exit is a single serialized handshake.
// PARAMETERS
//  SYNC_STAGES    2             flops in the ext_irq synchronizer (>=2)
//  XLEN           `CPU6_XLEN    datapath width; must equal `CPU6_XLEN
// PORTS
//  clk                in   1     sole clock
//  reset              in   1     asynchronous, active-low reset
//  excp_pc            in   XLEN  pc of the instruction currently at commit
//  excp_pc_vld        in   1     excp_pc holds a valid, not-yet-retired instruction
//  excp_illinstr      in   1     illegal instruction at commit (qualified by excp_pc_vld)
//  mret_req           in   1     mret at commit (qualified by excp_pc_vld)
//  tmr_irq_r          in   1     timer irq level
//  ext_irq            in   1     external irq level, asynchronous to clk
//  csr_mtie_r         in   1     mie.MTIE
//  csr_meie_r         in   1     mie.MEIE
//  csr_mtvec          in   XLEN  mtvec (base[XLEN-1:2], mode[1:0])
//  csr_mepc           in   XLEN  mepc, used as the mret target
//  flush_ack          in   1     pipeline confirms it has drained after flush_req
//  flush_req          out  1     request pipeline kill/drain; fetch stalls while high
//  excp_flush_pc_ena  out  1     one-cycle redirect strobe
//  excp_flush_pc      out  XLEN  redirect target
//  excp_mepc_ena      out  1     one-cycle mepc write strobe
//  excp_mepc          out  XLEN  latched trap pc
//  excp_mcause_ena    out  1     one-cycle mcause write strobe
//  excp_mcause        out  XLEN  latched cause
//  mstatus_mie        out  1     mstatus.MIE (owned here)
//  mstatus_mpie       out  1     mstatus.MPIE (owned here)
//  trap_busy          out  1     FSM not in IDLE
// BEHAVIOUR
//  - Reset: FSM=IDLE. All outputs are 0, including latched pc/cause, mie and mpie.
//  - irq_pend = mstatus_mie & ((ext_sync & csr_meie_r) | (tmr_irq_r & csr_mtie_r)). ext_sync is ext_irq after SYNC_STAGES flops.
//  - Priority in IDLE: excp_illinstr > ext irq > timer irq > mret_req. Every source is qualified by excp_pc_vld.
//  - mcause encoding: illinstr = 2; ext = {1'b1,…,11}; timer = {1'b1,…,7}. The MSB is bit XLEN-1.
//  - IDLE->DRAIN on a trap:
//      * latch excp_pc and the cause;
//      * flush_req=1 starting the next cycle, held until flush_ack.
//  - DRAIN->COMMIT on flush_ack=1. flush_ack may already be high on entry, giving a minimum of 1 cycle in DRAIN.
//  - COMMIT (1 cycle):
//      * excp_mepc_ena=excp_mcause_ena=1;
//      * mpie<=mie, mie<=0;
//      * goes to REDIRECT.
//  - REDIRECT (1 cycle): excp_flush_pc_ena=1 and excp_flush_pc=handler; goes to IDLE.
//  - The handler is {csr_mtvec[XLEN-1:2],2'b00}. csr_mtvec is sampled in REDIRECT.
//  - Trap latency: request at cycle t, ack at t+1, gives mepc write at t+2 and redirect at t+3.
//  - mret in IDLE (no trap winning) -> RET (1 cycle):
//      * excp_flush_pc_ena=1, excp_flush_pc=csr_mepc;
//      * mie<=mpie, mpie<=1;
//      * goes to IDLE. There is no drain: commit-stage mret already flushes younger ops.
//  - Outside IDLE, all new requests are ignored. Irq levels are re-evaluated in IDLE.
//  - An illinstr seen while busy is dropped: it belongs to a killed instruction.
//  - Strobes are never asserted in the same cycle as flush_req rising. At most one redirect per trap.
//  - Reset asserted mid-sequence aborts immediately. No partial CSR write survives into the post-reset state.
// CONFIGURATION
//  CPU6_TRAP_VECTORED_EN defined:
//      * if csr_mtvec[1:0]==2'b01 and the cause is an interrupt, handler = base + 4*cause[XLEN-2:0];
//      * exceptions always go to base;
//      * mode 2'b1x is treated as direct.
//  Not defined: mtvec[1:0] is ignored and the handler is always base.
// STRUCTURE
//  - defines.v (shared):
//      * CPU6_MCAUSE_ILLINSTR, CPU6_MCAUSE_MTI and CPU6_MCAUSE_MEI constants;
//      * 3-bit state encodings CPU6_TRAP_IDLE/DRAIN/COMMIT/REDIRECT/RET.
//  - Sub-module cpu6_irq_sync: SYNC_STAGES-deep reset-to-0 synchronizer for ext_irq.
// TESTING
//  1. mie=1, mtvec=0x100. illinstr at pc 0x40, ack 1 cycle later:
//     -> mepc=0x40, mcause=2 at t+2; redirect to 0x100 at t+3; mie=0, mpie=1.
//  2. Timer and ext irq both pending, MTIE=MEIE=1:
//     -> mcause=0x8000000B. Timer is taken after the first trap, only once mret restores mie=1.
//  3. illinstr and mret in the same cycle -> trap taken, no RET.
//     Then mret with mepc=0x44 -> redirect to 0x44, mie restored.
//  4. Hold flush_ack low for 5 cycles -> flush_req stays high 5 cycles, no strobes. Toggling irqs during DRAIN is ignored.
//  5. Assert reset during COMMIT -> all outputs 0 next edge. The FSM sits in IDLE after release.
//  6. CPU6_TRAP_VECTORED_EN, mtvec=0x201, timer irq -> redirect to 0x21C. Illinstr -> redirect to 0x200.

Source files
------------

// File: rtl/cpu6_trap_ctrl_pkg.sv
// Shared constants and state encodings for the cpu6 trap sequencer.
// Supplies a default CPU6_XLEN when the shared defines have not been read.
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

package cpu6_trap_ctrl_pkg;

  localparam int unsigned CPU6_XLEN_P = `CPU6_XLEN;

  localparam int unsigned CPU6_MCAUSE_ILLINSTR = 2;
  localparam int unsigned CPU6_MCAUSE_MTI      = 7;
  localparam int unsigned CPU6_MCAUSE_MEI      = 11;

  typedef enum logic [2:0] {
    CPU6_TRAP_IDLE     = 3'd0,
    CPU6_TRAP_DRAIN    = 3'd1,
    CPU6_TRAP_COMMIT   = 3'd2,
    CPU6_TRAP_REDIRECT = 3'd3,
    CPU6_TRAP_RET      = 3'd4
  } trap_state_e;

endpackage

// File: rtl/cpu6_trap_ctrl_if.sv
// Pipeline flush/redirect handshake between the trap sequencer (master)
// and the fetch/commit pipeline (slave).
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

interface cpu6_trap_ctrl_if #(
  parameter int unsigned XLEN = `CPU6_XLEN
);
  logic            flush_req;
  logic            flush_ack;
  logic            excp_flush_pc_ena;
  logic [XLEN-1:0] excp_flush_pc;

  modport master (
    output flush_req,
    output excp_flush_pc_ena,
    output excp_flush_pc,
    input  flush_ack
  );

  modport slave (
    input  flush_req,
    input  excp_flush_pc_ena,
    input  excp_flush_pc,
    output flush_ack
  );
endinterface

// File: rtl/cpu6_trap_ctrl_irq_sync.sv
// Reset-to-0 multi-flop synchronizer for the asynchronous external irq level.
// SYNC_STAGES must be at least 2.
module cpu6_irq_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
    end
  end

  always_comb q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cpu6_trap_ctrl.sv
// cpu6 trap sequencer: arbitrates trap sources, drains the pipeline, writes
// mepc/mcause, stacks mstatus and redirects fetch; also sequences mret.
// Optional macro CPU6_TRAP_VECTORED_EN enables vectored interrupt handlers.
module cpu6_trap_ctrl
  import cpu6_trap_ctrl_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned XLEN        = `CPU6_XLEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [XLEN-1:0]   excp_pc,
  input  logic              excp_pc_vld,
  input  logic              excp_illinstr,
  input  logic              mret_req,
  input  logic              tmr_irq_r,
  input  logic              ext_irq,
  input  logic              csr_mtie_r,
  input  logic              csr_meie_r,
  input  logic [XLEN-1:0]   csr_mtvec,
  input  logic [XLEN-1:0]   csr_mepc,
  cpu6_trap_ctrl_if.master  flush_if,
  output logic              excp_mepc_ena,
  output logic [XLEN-1:0]   excp_mepc,
  output logic              excp_mcause_ena,
  output logic [XLEN-1:0]   excp_mcause,
  output logic              mstatus_mie,
  output logic              mstatus_mpie,
  output logic              trap_busy
);

  trap_state_e     state;
  logic            ext_sync;
  logic            irq_ext;
  logic            irq_tmr;
  logic            take_ill;
  logic            take_ext;
  logic            take_tmr;
  logic            take_ret;
  logic [XLEN-1:0] cause_nxt;
  logic [XLEN-1:0] handler;
  logic            flush_req_q;
  logic            flush_pc_ena_q;

  cpu6_irq_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_irq_sync (
    .clk   (clk),
    .rst_n (reset),
    .d     (ext_irq),
    .q     (ext_sync)
  );

  // Fixed priority: illinstr > ext irq > timer irq > mret, all gated by excp_pc_vld.
  always_comb begin
    irq_ext   = mstatus_mie & ext_sync & csr_meie_r;
    irq_tmr   = mstatus_mie & tmr_irq_r & csr_mtie_r;
    take_ill  = excp_pc_vld & excp_illinstr;
    take_ext  = excp_pc_vld & ~excp_illinstr & irq_ext;
    take_tmr  = excp_pc_vld & ~excp_illinstr & ~irq_ext & irq_tmr;
    take_ret  = excp_pc_vld & mret_req & ~excp_illinstr & ~irq_ext & ~irq_tmr;
    cause_nxt = '0;
    if (take_ill) begin
      cause_nxt = XLEN'(CPU6_MCAUSE_ILLINSTR);
    end else if (take_ext) begin
      cause_nxt = {1'b1, (XLEN-1)'(CPU6_MCAUSE_MEI)};
    end else if (take_tmr) begin
      cause_nxt = {1'b1, (XLEN-1)'(CPU6_MCAUSE_MTI)};
    end
  end

`ifdef CPU6_TRAP_VECTORED_EN
  // Only mode 2'b01 with an interrupt cause vectors; 2'b1x falls back to direct.
  always_comb begin
    handler = {csr_mtvec[XLEN-1:2], 2'b00};
    if (csr_mtvec[1:0] == 2'b01 && excp_mcause[XLEN-1]) begin
      handler = {csr_mtvec[XLEN-1:2], 2'b00} + {excp_mcause[XLEN-3:0], 2'b00};
    end
  end
`else
  logic unused_mtvec_mode;
  always_comb begin
    handler           = {csr_mtvec[XLEN-1:2], 2'b00};
    unused_mtvec_mode = ^csr_mtvec[1:0];
  end
`endif

  // Target is muxed live so csr_mtvec/csr_mepc are sampled in the strobe cycle itself.
  always_comb begin
    flush_if.flush_req         = flush_req_q;
    flush_if.excp_flush_pc_ena = flush_pc_ena_q;
    flush_if.excp_flush_pc     = '0;
    case (state)
      CPU6_TRAP_REDIRECT: flush_if.excp_flush_pc = handler;
      CPU6_TRAP_RET:      flush_if.excp_flush_pc = csr_mepc;
      default:            flush_if.excp_flush_pc = '0;
    endcase
    trap_busy = (state != CPU6_TRAP_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= CPU6_TRAP_IDLE;
      flush_req_q     <= 1'b0;
      flush_pc_ena_q  <= 1'b0;
      excp_mepc_ena   <= 1'b0;
      excp_mcause_ena <= 1'b0;
      excp_mepc       <= '0;
      excp_mcause     <= '0;
      mstatus_mie     <= 1'b0;
      mstatus_mpie    <= 1'b0;
    end else begin
      excp_mepc_ena   <= 1'b0;
      excp_mcause_ena <= 1'b0;
      flush_pc_ena_q  <= 1'b0;
      case (state)
        CPU6_TRAP_IDLE: begin
          if (take_ill || take_ext || take_tmr) begin
            state       <= CPU6_TRAP_DRAIN;
            flush_req_q <= 1'b1;
            excp_mepc   <= excp_pc;
            excp_mcause <= cause_nxt;
          end else if (take_ret) begin
            state          <= CPU6_TRAP_RET;
            flush_pc_ena_q <= 1'b1;
          end
        end
        CPU6_TRAP_DRAIN: begin
          if (flush_if.flush_ack) begin
            state           <= CPU6_TRAP_COMMIT;
            flush_req_q     <= 1'b0;
            excp_mepc_ena   <= 1'b1;
            excp_mcause_ena <= 1'b1;
          end
        end
        CPU6_TRAP_COMMIT: begin
          mstatus_mpie   <= mstatus_mie;
          mstatus_mie    <= 1'b0;
          state          <= CPU6_TRAP_REDIRECT;
          flush_pc_ena_q <= 1'b1;
        end
        CPU6_TRAP_REDIRECT: begin
          state <= CPU6_TRAP_IDLE;
        end
        CPU6_TRAP_RET: begin
          mstatus_mie  <= mstatus_mpie;
          mstatus_mpie <= 1'b1;
          state        <= CPU6_TRAP_IDLE;
        end
        default: begin
          state <= CPU6_TRAP_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu6_trap_ctrl.sv
// Directed self-checking bench for cpu6_trap_ctrl (XLEN 32).
`ifndef CPU6_XLEN
`define CPU6_XLEN 32
`endif

module tb_cpu6_trap_ctrl;

  localparam int unsigned XLEN = `CPU6_XLEN;

  logic            clk = 1'b0;
  logic            reset;
  logic [XLEN-1:0] excp_pc;
  logic            excp_pc_vld;
  logic            excp_illinstr;
  logic            mret_req;
  logic            tmr_irq_r;
  logic            ext_irq;
  logic            csr_mtie_r;
  logic            csr_meie_r;
  logic [XLEN-1:0] csr_mtvec;
  logic [XLEN-1:0] csr_mepc;
  logic            excp_mepc_ena;
  logic [XLEN-1:0] excp_mepc;
  logic            excp_mcause_ena;
  logic [XLEN-1:0] excp_mcause;
  logic            mstatus_mie;
  logic            mstatus_mpie;
  logic            trap_busy;

  int n_checks = 0;
  int n_fail   = 0;

  cpu6_trap_ctrl_if #(.XLEN(XLEN)) flush_if ();

  cpu6_trap_ctrl #(
    .SYNC_STAGES (2),
    .XLEN        (XLEN)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .excp_pc         (excp_pc),
    .excp_pc_vld     (excp_pc_vld),
    .excp_illinstr   (excp_illinstr),
    .mret_req        (mret_req),
    .tmr_irq_r       (tmr_irq_r),
    .ext_irq         (ext_irq),
    .csr_mtie_r      (csr_mtie_r),
    .csr_meie_r      (csr_meie_r),
    .csr_mtvec       (csr_mtvec),
    .csr_mepc        (csr_mepc),
    .flush_if        (flush_if),
    .excp_mepc_ena   (excp_mepc_ena),
    .excp_mepc       (excp_mepc),
    .excp_mcause_ena (excp_mcause_ena),
    .excp_mcause     (excp_mcause),
    .mstatus_mie     (mstatus_mie),
    .mstatus_mpie    (mstatus_mpie),
    .trap_busy       (trap_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mret through RET and back to IDLE; leaves mie=old mpie, mpie=1.
  task automatic do_mret(input logic [XLEN-1:0] pc);
    excp_pc_vld = 1'b1;
    mret_req    = 1'b1;
    excp_pc     = pc;
    csr_mepc    = pc;
    tick();
    mret_req    = 1'b0;
    excp_pc_vld = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    n_checks++;
    if (flush_if.flush_req !== 1'b0 || flush_if.excp_flush_pc_ena !== 1'b0 ||
        flush_if.excp_flush_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_flush: req=%b ena=%b pc=%h required 0 0 0",
               flush_if.flush_req, flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc);
    end
    n_checks++;
    if (excp_mepc_ena !== 1'b0 || excp_mcause_ena !== 1'b0 || excp_mepc !== 32'h0 ||
        excp_mcause !== 32'h0 || mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b0 ||
        trap_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_csr: mepc_ena=%b mcause_ena=%b mepc=%h mcause=%h mie=%b mpie=%b busy=%b required all 0",
               excp_mepc_ena, excp_mcause_ena, excp_mepc, excp_mcause, mstatus_mie, mstatus_mpie, trap_busy);
    end
  endtask

  task automatic test_mret();
    excp_pc_vld = 1'b1;
    mret_req    = 1'b1;
    excp_pc     = 32'h10;
    csr_mepc    = 32'h10;
    tick();
    mret_req    = 1'b0;
    excp_pc_vld = 1'b0;
    n_checks++;
    if (flush_if.excp_flush_pc_ena !== 1'b1 || flush_if.excp_flush_pc !== 32'h10 ||
        flush_if.flush_req !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_redirect: ena=%b pc=%h req=%b required 1 00000010 0",
               flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc, flush_if.flush_req);
    end
    tick();
    n_checks++;
    if (mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b1 || flush_if.excp_flush_pc_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL mret_stack: mie=%b mpie=%b ena=%b required 0 1 0",
               mstatus_mie, mstatus_mpie, flush_if.excp_flush_pc_ena);
    end
    do_mret(32'h14);
    n_checks++;
    if (mstatus_mie !== 1'b1 || mstatus_mpie !== 1'b1) begin
      n_fail++;
      $display("FAIL mret_enable: mie=%b mpie=%b required 1 1", mstatus_mie, mstatus_mpie);
    end
  endtask

  task automatic test_illinstr();
    csr_mtvec     = 32'h100;
    excp_pc       = 32'h40;
    excp_pc_vld   = 1'b1;
    excp_illinstr = 1'b1;
    tick();
    excp_pc_vld   = 1'b0;
    excp_illinstr = 1'b0;
    flush_if.flush_ack = 1'b1;
    n_checks++;
    if (flush_if.flush_req !== 1'b1 || excp_mepc_ena !== 1'b0 || excp_mcause_ena !== 1'b0 ||
        flush_if.excp_flush_pc_ena !== 1'b0 || trap_busy !== 1'b1) begin
      n_fail++;
      $display("FAIL ill_drain: req=%b mepc_ena=%b mcause_ena=%b pc_ena=%b busy=%b required 1 0 0 0 1",
               flush_if.flush_req, excp_mepc_ena, excp_mcause_ena, flush_if.excp_flush_pc_ena, trap_busy);
    end
    tick();
    flush_if.flush_ack = 1'b0;
    n_checks++;
    if (excp_mepc_ena !== 1'b1 || excp_mcause_ena !== 1'b1 || excp_mepc !== 32'h40 ||
        excp_mcause !== 32'h2 || flush_if.flush_req !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_commit: mepc_ena=%b mcause_ena=%b mepc=%h mcause=%h req=%b required 1 1 00000040 00000002 0",
               excp_mepc_ena, excp_mcause_ena, excp_mepc, excp_mcause, flush_if.flush_req);
    end
    tick();
    n_checks++;
    if (flush_if.excp_flush_pc_ena !== 1'b1 || flush_if.excp_flush_pc !== 32'h100 ||
        mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b1 || excp_mepc_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_redirect: ena=%b pc=%h mie=%b mpie=%b mepc_ena=%b required 1 00000100 0 1 0",
               flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc, mstatus_mie, mstatus_mpie, excp_mepc_ena);
    end
    tick();
    n_checks++;
    if (trap_busy !== 1'b0 || flush_if.excp_flush_pc_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL ill_idle: busy=%b ena=%b required 0 0", trap_busy, flush_if.excp_flush_pc_ena);
    end
    do_mret(32'h40);
  endtask

  task automatic test_mret_collision();
    excp_pc       = 32'h44;
    excp_pc_vld   = 1'b1;
    excp_illinstr = 1'b1;
    mret_req      = 1'b1;
    tick();
    excp_pc_vld   = 1'b0;
    excp_illinstr = 1'b0;
    mret_req      = 1'b0;
    flush_if.flush_ack = 1'b1;
    n_checks++;
    if (flush_if.flush_req !== 1'b1 || flush_if.excp_flush_pc_ena !== 1'b0 || excp_mcause !== 32'h2) begin
      n_fail++;
      $display("FAIL coll_trap: req=%b ena=%b mcause=%h required 1 0 00000002",
               flush_if.flush_req, flush_if.excp_flush_pc_ena, excp_mcause);
    end
    tick();
    flush_if.flush_ack = 1'b0;
    tick();
    n_checks++;
    if (flush_if.excp_flush_pc !== 32'h100 || flush_if.excp_flush_pc_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_redirect: pc=%h ena=%b required 00000100 1",
               flush_if.excp_flush_pc, flush_if.excp_flush_pc_ena);
    end
    tick();
    n_checks++;
    if (trap_busy !== 1'b0 || flush_if.excp_flush_pc_ena !== 1'b0 || mstatus_mie !== 1'b0) begin
      n_fail++;
      $display("FAIL coll_no_ret: busy=%b ena=%b mie=%b required 0 0 0",
               trap_busy, flush_if.excp_flush_pc_ena, mstatus_mie);
    end
    excp_pc_vld = 1'b1;
    mret_req    = 1'b1;
    csr_mepc    = 32'h44;
    tick();
    excp_pc_vld = 1'b0;
    mret_req    = 1'b0;
    n_checks++;
    if (flush_if.excp_flush_pc_ena !== 1'b1 || flush_if.excp_flush_pc !== 32'h44) begin
      n_fail++;
      $display("FAIL coll_mret: ena=%b pc=%h required 1 00000044",
               flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc);
    end
    tick();
    n_checks++;
    if (mstatus_mie !== 1'b1) begin
      n_fail++;
      $display("FAIL coll_mie: mie=%b required 1", mstatus_mie);
    end
  endtask

  task automatic test_irq_priority();
    csr_mtie_r = 1'b1;
    csr_meie_r = 1'b1;
    tmr_irq_r  = 1'b1;
    ext_irq    = 1'b1;
    tick();
    tick();
    tick();
    excp_pc     = 32'h80;
    excp_pc_vld = 1'b1;
    flush_if.flush_ack = 1'b1;
    tick();
    ext_irq = 1'b0;
    n_checks++;
    if (trap_busy !== 1'b1 || excp_mcause !== 32'h8000_000B || excp_mepc !== 32'h80) begin
      n_fail++;
      $display("FAIL irq_ext_cause: busy=%b mcause=%h mepc=%h required 1 8000000b 00000080",
               trap_busy, excp_mcause, excp_mepc);
    end
    tick();
    tick();
    tick();
    tick();
    tick();
    n_checks++;
    if (trap_busy !== 1'b0 || mstatus_mie !== 1'b0 || flush_if.flush_req !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_masked: busy=%b mie=%b req=%b required 0 0 0",
               trap_busy, mstatus_mie, flush_if.flush_req);
    end
    mret_req = 1'b1;
    csr_mepc = 32'h80;
    tick();
    mret_req = 1'b0;
    n_checks++;
    if (flush_if.excp_flush_pc_ena !== 1'b1 || flush_if.excp_flush_pc !== 32'h80) begin
      n_fail++;
      $display("FAIL irq_mret: ena=%b pc=%h required 1 00000080",
               flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc);
    end
    tick();
    n_checks++;
    if (mstatus_mie !== 1'b1 || trap_busy !== 1'b0) begin
      n_fail++;
      $display("FAIL irq_restored: mie=%b busy=%b required 1 0", mstatus_mie, trap_busy);
    end
    tick();
    tmr_irq_r   = 1'b0;
    excp_pc_vld = 1'b0;
    n_checks++;
    if (trap_busy !== 1'b1 || excp_mcause !== 32'h8000_0007) begin
      n_fail++;
      $display("FAIL irq_tmr_cause: busy=%b mcause=%h required 1 80000007", trap_busy, excp_mcause);
    end
    tick();
    tick();
    tick();
    flush_if.flush_ack = 1'b0;
    do_mret(32'h80);
  endtask

  task automatic test_drain_hold();
    excp_pc       = 32'h50;
    excp_pc_vld   = 1'b1;
    excp_illinstr = 1'b1;
    flush_if.flush_ack = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (flush_if.flush_req !== 1'b1 || excp_mepc_ena !== 1'b0 || excp_mcause_ena !== 1'b0 ||
          flush_if.excp_flush_pc_ena !== 1'b0) begin
        n_fail++;
        $display("FAIL drain_hold[%0d]: req=%b mepc_ena=%b mcause_ena=%b pc_ena=%b required 1 0 0 0",
                 i, flush_if.flush_req, excp_mepc_ena, excp_mcause_ena, flush_if.excp_flush_pc_ena);
      end
      tmr_irq_r     = i[0];
      ext_irq       = ~i[0];
      excp_illinstr = i[0];
      excp_pc       = 32'h60;
      if (i == 4) flush_if.flush_ack = 1'b1;
      tick();
    end
    tmr_irq_r     = 1'b0;
    ext_irq       = 1'b0;
    excp_illinstr = 1'b0;
    excp_pc_vld   = 1'b0;
    flush_if.flush_ack = 1'b0;
    n_checks++;
    if (excp_mepc_ena !== 1'b1 || excp_mepc !== 32'h50 || excp_mcause !== 32'h2 ||
        flush_if.flush_req !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_commit: mepc_ena=%b mepc=%h mcause=%h req=%b required 1 00000050 00000002 0",
               excp_mepc_ena, excp_mepc, excp_mcause, flush_if.flush_req);
    end
    tick();
    tick();
    tick();
    tick();
    do_mret(32'h50);
  endtask

  task automatic test_reset_mid();
    excp_pc       = 32'h70;
    excp_pc_vld   = 1'b1;
    excp_illinstr = 1'b1;
    tick();
    excp_pc_vld   = 1'b0;
    excp_illinstr = 1'b0;
    flush_if.flush_ack = 1'b1;
    tick();
    n_checks++;
    if (excp_mepc_ena !== 1'b1 || mstatus_mie !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_commit: mepc_ena=%b mie=%b required 1 1", excp_mepc_ena, mstatus_mie);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if (excp_mepc_ena !== 1'b0 || excp_mcause_ena !== 1'b0 || excp_mepc !== 32'h0 ||
        excp_mcause !== 32'h0 || mstatus_mie !== 1'b0 || mstatus_mpie !== 1'b0 ||
        trap_busy !== 1'b0 || flush_if.flush_req !== 1'b0 || flush_if.excp_flush_pc_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_clear: mepc_ena=%b mcause_ena=%b mepc=%h mcause=%h mie=%b mpie=%b busy=%b req=%b ena=%b required all 0",
               excp_mepc_ena, excp_mcause_ena, excp_mepc, excp_mcause, mstatus_mie, mstatus_mpie,
               trap_busy, flush_if.flush_req, flush_if.excp_flush_pc_ena);
    end
    tick();
    reset = 1'b1;
    flush_if.flush_ack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (trap_busy !== 1'b0 || excp_mcause !== 32'h0 || mstatus_mpie !== 1'b0 ||
        flush_if.excp_flush_pc_ena !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: busy=%b mcause=%h mpie=%b ena=%b required 0 00000000 0 0",
               trap_busy, excp_mcause, mstatus_mpie, flush_if.excp_flush_pc_ena);
    end
  endtask

  task automatic test_vectored();
    logic [XLEN-1:0] exp_tmr_pc;
`ifdef CPU6_TRAP_VECTORED_EN
    exp_tmr_pc = 32'h21C;
`else
    exp_tmr_pc = 32'h200;
`endif
    do_mret(32'h8);
    do_mret(32'hC);
    csr_mtvec   = 32'h201;
    csr_mtie_r  = 1'b1;
    tmr_irq_r   = 1'b1;
    excp_pc     = 32'h90;
    excp_pc_vld = 1'b1;
    tick();
    tmr_irq_r   = 1'b0;
    excp_pc_vld = 1'b0;
    flush_if.flush_ack = 1'b1;
    tick();
    flush_if.flush_ack = 1'b0;
    n_checks++;
    if (excp_mcause !== 32'h8000_0007 || excp_mcause_ena !== 1'b1) begin
      n_fail++;
      $display("FAIL vec_cause: mcause=%h ena=%b required 80000007 1", excp_mcause, excp_mcause_ena);
    end
    tick();
    n_checks++;
    if (flush_if.excp_flush_pc_ena !== 1'b1 || flush_if.excp_flush_pc !== exp_tmr_pc) begin
      n_fail++;
      $display("FAIL vec_tmr_pc: ena=%b pc=%h required 1 %h",
               flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc, exp_tmr_pc);
    end
    tick();
    do_mret(32'h90);
    excp_pc       = 32'h94;
    excp_pc_vld   = 1'b1;
    excp_illinstr = 1'b1;
    tick();
    excp_pc_vld   = 1'b0;
    excp_illinstr = 1'b0;
    flush_if.flush_ack = 1'b1;
    tick();
    flush_if.flush_ack = 1'b0;
    tick();
    n_checks++;
    if (flush_if.excp_flush_pc_ena !== 1'b1 || flush_if.excp_flush_pc !== 32'h200) begin
      n_fail++;
      $display("FAIL vec_ill_pc: ena=%b pc=%h required 1 00000200",
               flush_if.excp_flush_pc_ena, flush_if.excp_flush_pc);
    end
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d failures", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    reset         = 1'b0;
    excp_pc       = '0;
    excp_pc_vld   = 1'b0;
    excp_illinstr = 1'b0;
    mret_req      = 1'b0;
    tmr_irq_r     = 1'b0;
    ext_irq       = 1'b0;
    csr_mtie_r    = 1'b0;
    csr_meie_r    = 1'b0;
    csr_mtvec     = '0;
    csr_mepc      = '0;
    flush_if.flush_ack = 1'b0;
    tick();
    tick();
    test_reset();
    reset = 1'b1;
    tick();
    test_mret();
    test_illinstr();
    test_mret_collision();
    test_irq_priority();
    test_drain_hold();
    test_reset_mid();
    test_vectored();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
